// File: rtl/mips_trace_buffer.sv
// Change-triggered execution tracer with a DEPTH-entry FIFO readout.
// Optional per-record CYCLES timestamp and RD_TIME port: TRACE_TIMESTAMP_EN.
module mips_trace_buffer #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int MAX_CYCLES  = 80,
  parameter int STALL_LIMIT = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [DATA_W-1:0]        PC,
  input  logic [DATA_W-1:0]        INS,
  input  logic [DATA_W-1:0]        RESULT,
  input  logic                     RD_EN,
  output logic [DATA_W-1:0]        RD_PC,
  output logic [DATA_W-1:0]        RD_INS,
  output logic [DATA_W-1:0]        RD_RESULT,
  output logic                     RD_VALID,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [1:0]               STATE,
  output logic                     OVERFLOW,
  output logic                     HALTED,
`ifdef TRACE_TIMESTAMP_EN
  output logic [15:0]              RD_TIME,
`endif
  output logic [15:0]              CYCLES
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_LIMIT) + 1;
  localparam int TW = 3 * DATA_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RW = TW + 16;
`else
  localparam int RW = TW;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [15:0]     cycles_q, cycles_d;
  logic            ovf_q, ovf_d;
  logic            halt_q, halt_d;
  logic            first_q, first_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [TW-1:0]   prev_q, prev_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            rd_valid_q, rd_valid_d;

  logic [RW-1:0]   mem [DEPTH];
  logic [TW-1:0]   sample;
  logic [RW-1:0]   wdata;
  logic            we;
  logic            clr;

  assign sample = {PC, INS, RESULT};
`ifdef TRACE_TIMESTAMP_EN
  assign wdata   = {cycles_d, sample};
  assign RD_TIME = rd_q[TW+15:TW];
`else
  assign wdata = sample;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cycles_d   = cycles_q;
    ovf_d      = ovf_q;
    halt_d     = halt_q;
    first_d    = first_q;
    stall_d    = stall_q;
    prev_d     = prev_q;
    rd_d       = rd_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      S_IDLE: clr = START;
      S_RUN: begin
        cycles_d = cycles_q + 16'd1;
        prev_d   = sample;
        first_d  = 1'b0;
        if (first_q || PC != prev_q[TW-1:2*DATA_W])
          stall_d = '0;
        else
          stall_d = stall_q + SW'(1);
        if (first_q || sample != prev_q) begin
          if (count_q == CW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            count_d = count_q + CW'(1);
          end
        end
        // stall wins over budget so HALTED reflects a coincident halt
        if (stall_d == SW'(STALL_LIMIT - 1)) begin
          state_d = S_DONE;
          halt_d  = 1'b1;
        end else if (cycles_d == 16'(MAX_CYCLES)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (START) begin
          clr = 1'b1;
        end else if (RD_EN && count_q != '0) begin
          rd_d       = mem[rptr_q];
          rd_valid_d = 1'b1;
          rptr_d     = rptr_q + AW'(1);
          count_d    = count_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d  = S_RUN;
      count_d  = '0;
      wptr_d   = '0;
      rptr_d   = '0;
      cycles_d = '0;
      ovf_d    = 1'b0;
      halt_d   = 1'b0;
      first_d  = 1'b1;
      stall_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cycles_q   <= '0;
      ovf_q      <= 1'b0;
      halt_q     <= 1'b0;
      first_q    <= 1'b0;
      stall_q    <= '0;
      prev_q     <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cycles_q   <= cycles_d;
      ovf_q      <= ovf_d;
      halt_q     <= halt_d;
      first_q    <= first_d;
      stall_q    <= stall_d;
      prev_q     <= prev_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[wptr_q] <= wdata;
  end

  assign RD_PC     = rd_q[TW-1:2*DATA_W];
  assign RD_INS    = rd_q[2*DATA_W-1:DATA_W];
  assign RD_RESULT = rd_q[DATA_W-1:0];
  assign RD_VALID  = rd_valid_q;
  assign COUNT     = count_q;
  assign STATE     = state_q;
  assign OVERFLOW  = ovf_q;
  assign HALTED    = halt_q;
  assign CYCLES    = cycles_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Randomized bench for mips_trace_buffer against a sequence-level trace model.
// Define TRACE_TIMESTAMP_EN to also check RD_TIME.
module tb_mips_trace_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int MAXC  = 80;
  localparam int SL    = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          RD_EN = 1'b0;
  logic [W-1:0]  PC = '0;
  logic [W-1:0]  INS = '0;
  logic [W-1:0]  RESULT = '0;
  logic [W-1:0]  RD_PC, RD_INS, RD_RESULT;
  logic          RD_VALID, OVERFLOW, HALTED;
  logic [6:0]    COUNT;
  logic [1:0]    STATE;
  logic [15:0]   CYCLES;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]   RD_TIME;
`endif

  mips_trace_buffer #(
    .DATA_W(W), .DEPTH(DEPTH), .MAX_CYCLES(MAXC), .STALL_LIMIT(SL)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .PC(PC), .INS(INS), .RESULT(RESULT), .RD_EN(RD_EN),
    .RD_PC(RD_PC), .RD_INS(RD_INS), .RD_RESULT(RD_RESULT),
    .RD_VALID(RD_VALID), .COUNT(COUNT), .STATE(STATE),
    .OVERFLOW(OVERFLOW), .HALTED(HALTED),
`ifdef TRACE_TIMESTAMP_EN
    .RD_TIME(RD_TIME),
`endif
    .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] s_pc [MAXC];
  logic [W-1:0] s_ins[MAXC];
  logic [W-1:0] s_res[MAXC];
  int           exp_idx[$];
  int           exp_end;
  bit           exp_halt;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic gen(input int mode);
    for (int i = 0; i < MAXC; i++) begin
      case (mode)
        0: begin
          s_pc[i]  = 4 * i;
          s_ins[i] = $urandom;
          s_res[i] = $urandom;
        end
        1: begin
          if (i > 0 && $urandom_range(0, 2) == 0) s_pc[i] = s_pc[i-1];
          else s_pc[i] = 4 * $urandom_range(0, 7);
          s_ins[i] = 32'h2000_0000 | s_pc[i];
          s_res[i] = $urandom_range(0, 1);
        end
        2: begin
          s_pc[i]  = (i < 3) ? 4 * i : 8;
          s_ins[i] = 32'h0800_0002;
          s_res[i] = 32'h0;
        end
        default: begin
          s_pc[i]  = 32'h10;
          s_ins[i] = 32'h0000_0020;
          s_res[i] = (i < 3) ? i + 1 : 3;
        end
      endcase
    end
  endtask

  // Run ends at the first cycle closing SL equal PCs, else at MAXC;
  // a record exists wherever the sampled tuple differs from its predecessor.
  task automatic model();
    bit hit;
    exp_end  = MAXC;
    exp_halt = 0;
    for (int k = 1; k <= MAXC; k++) begin
      hit = (k >= SL);
      for (int j = k - SL; j < k; j++)
        if (j >= 0 && s_pc[j] != s_pc[k-1]) hit = 0;
      if (hit) begin
        exp_end  = k;
        exp_halt = 1;
        break;
      end
    end
    exp_idx.delete();
    for (int i = 0; i < exp_end; i++)
      if (i == 0 || s_pc[i] != s_pc[i-1] || s_ins[i] != s_ins[i-1] ||
          s_res[i] != s_res[i-1])
        exp_idx.push_back(i);
  endtask

  task automatic start_run(input bit with_rd);
    START = 1'b1;
    RD_EN = with_rd;
    step();
    START = 1'b0;
    RD_EN = 1'b0;
    check("start_state", STATE, 1);
    check("start_count", COUNT, 0);
    check("start_cycles", CYCLES, 0);
    check("start_ovf", OVERFLOW, 0);
    check("start_halt", HALTED, 0);
    check("start_novalid", RD_VALID, 0);
  endtask

  task automatic run_trace(input int mode, input bit start_rd,
                           input bit do_pop);
    int k;
    int stored;
    int idx;
    gen(mode);
    model();
    stored = (exp_idx.size() > DEPTH) ? DEPTH : exp_idx.size();
    start_run(start_rd);
    k = 0;
    while (STATE == 2'd1 && k < MAXC) begin
      PC     = s_pc[k];
      INS    = s_ins[k];
      RESULT = s_res[k];
      RD_EN  = 1'($urandom_range(0, 1));
      step();
      k++;
      check("run_nopop", RD_VALID, 0);
    end
    RD_EN = 1'b0;
    check("end_state", STATE, 2);
    check("end_cycles", CYCLES, exp_end);
    check("end_halted", HALTED, exp_halt);
    check("end_ovf", OVERFLOW, exp_idx.size() > DEPTH);
    check("end_count", COUNT, stored);
    if (do_pop) begin
      for (int i = 0; i < stored; i++) begin
        idx   = exp_idx[i];
        RD_EN = 1'b1;
        step();
        check("pop_valid", RD_VALID, 1);
        check("pop_pc", RD_PC, s_pc[idx]);
        check("pop_ins", RD_INS, s_ins[idx]);
        check("pop_res", RD_RESULT, s_res[idx]);
`ifdef TRACE_TIMESTAMP_EN
        check("pop_time", RD_TIME, idx + 1);
`endif
      end
      RD_EN = 1'b0;
      check("pop_empty", COUNT, 0);
      RD_EN = 1'b1;
      step();
      RD_EN = 1'b0;
      check("empty_novalid", RD_VALID, 0);
      if (stored > 0) check("empty_hold", RD_PC, s_pc[exp_idx[stored-1]]);
    end
  endtask

  initial begin
    #12;
    check("rst_state", STATE, 0);
    check("rst_count", COUNT, 0);
    check("rst_cycles", CYCLES, 0);
    check("rst_valid", RD_VALID, 0);
    check("rst_pc", RD_PC, 0);
    check("rst_flags", {OVERFLOW, HALTED}, 0);
    RST = 1'b1;
    step();
    check("idle_state", STATE, 0);
    run_trace(2, 1'b0, 1'b1);
    run_trace(3, 1'b0, 1'b1);
    run_trace(0, 1'b0, 1'b0);
    run_trace(1, 1'b1, 1'b1);
    for (int r = 0; r < 6; r++) run_trace(1, 1'b0, 1'b1);
    run_trace(0, 1'b0, 1'b1);
    gen(0);
    start_run(1'b0);
    for (int k = 0; k < 10; k++) begin
      PC     = s_pc[k];
      INS    = s_ins[k];
      RESULT = s_res[k];
      step();
    end
    check("mid_cycles", CYCLES, 10);
    #2 RST = 1'b0;
    #1;
    check("arst_state", STATE, 0);
    check("arst_count", COUNT, 0);
    check("arst_cycles", CYCLES, 0);
    #1 RST = 1'b1;
    step();
    check("post_rst_idle", STATE, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
